fadd_pipe: RTL and testbench

Pipelined, parametrised IEEE-754 floating-point adder/subtractor with valid/ready handshaking, four rounding modes, full subnormal (gradual underflow) support and sticky accumulated exception flags. It is the sequential successor to the team's combinational single-precision adder. It sits between the operand issue logic and the result writeback/FPU status register, and accepts one operation per cycle when not back-pressured.

---
 rtl/fadd_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_fadd_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with valid/ready flow control,
// four rounding modes, gradual underflow and sticky accumulated exception flags.
module fadd_pipe #(
  parameter int exp  = 8,
  parameter int frac = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [exp+frac:0] a,
  input  logic [exp+frac:0] b,
  input  logic              op,
  input  logic [1:0]        round_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [exp+frac:0] r,
  output logic [4:0]        flags,
  output logic [4:0]        flags_acc,
  input  logic              flags_clr
);
  localparam int W  = exp + frac + 1;
  localparam int XW = frac + 4;
  localparam logic [exp-1:0] E_ONES = '1;
  localparam logic [exp-1:0] E_ONE  = exp'(1);
  localparam logic [exp-1:0] E_XW   = exp'(XW);
  localparam logic [exp:0]   X_ONE  = (exp+1)'(1);
  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

  function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic rs);
    case (rm)
      RNE:     return g & (rs | lsb);
      RTZ:     return 1'b0;
      RUP:     return (g | rs) & !sign;
      default: return (g | rs) & sign;
    endcase
  endfunction

  function automatic logic [W-1:0] ovf_result(input logic [1:0] rm, input logic sign);
    if (rm == RNE || (rm == RUP && !sign) || (rm == RDN && sign))
      return {sign, E_ONES, {frac{1'b0}}};
    return {sign, {(exp-1){1'b1}}, 1'b0, {frac{1'b1}}};
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic           sa, sb, a_nan, b_nan, a_inf, b_inf, swap, stk;
  logic [exp-1:0] ea, eb, e_big, e_sml, eff_big, eff_sml, diff;
  logic [frac-1:0] fa, fb, f_big, f_sml;
  logic [XW-1:0]  ext_sml, aligned;
  logic           special_s1, inv_s1;
  logic [W-1:0]   spec_s1;

  assign sa    = a[W-1];
  assign sb    = b[W-1] ^ op;
  assign ea    = a[W-2:frac];
  assign eb    = b[W-2:frac];
  assign fa    = a[frac-1:0];
  assign fb    = b[frac-1:0];
  assign a_nan = (ea == E_ONES) && (fa != '0);
  assign b_nan = (eb == E_ONES) && (fb != '0);
  assign a_inf = (ea == E_ONES) && (fa == '0);
  assign b_inf = (eb == E_ONES) && (fb == '0);
  assign swap  = {eb, fb} > {ea, fa};
  assign e_big = swap ? eb : ea;
  assign e_sml = swap ? ea : eb;
  assign f_big = swap ? fb : fa;
  assign f_sml = swap ? fa : fb;

  always_comb begin
    special_s1 = 1'b0;
    inv_s1     = 1'b0;
    spec_s1    = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      special_s1 = 1'b1;
      inv_s1     = 1'b1;
      spec_s1    = {1'b0, E_ONES, 1'b1, {(frac-1){1'b0}}};
    end else if (a_inf) begin
      special_s1 = 1'b1;
      spec_s1    = {sa, ea, fa};
    end else if (b_inf) begin
      special_s1 = 1'b1;
      spec_s1    = {sb, eb, fb};
    end
  end

  // Subnormals align as if their exponent were 1; shifted-out bits collapse into sticky.
  always_comb begin
    eff_big = (e_big == '0) ? E_ONE : e_big;
    eff_sml = (e_sml == '0) ? E_ONE : e_sml;
    diff    = eff_big - eff_sml;
    ext_sml = {e_sml != '0, f_sml, 3'b000};
    if (diff >= E_XW) begin
      aligned = '0;
      stk     = |ext_sml;
    end else begin
      aligned = ext_sml >> diff;
      stk     = |(ext_sml & ~({XW{1'b1}} << diff));
    end
    aligned[0] = aligned[0] | stk;
  end

  // Stage 1 register: aligned operands
  logic           vld_p1, special_p1, inv_p1, sign_p1, sub_p1;
  logic [1:0]     rm_p1;
  logic [W-1:0]   spec_p1;
  logic [exp-1:0] exp_p1;
  logic [XW-1:0]  big_p1, sml_p1;

  always_ff @(posedge clk) begin
    if (adv) begin
      special_p1 <= special_s1;
      inv_p1     <= inv_s1;
      spec_p1    <= spec_s1;
      sign_p1    <= swap ? sb : sa;
      sub_p1     <= sa ^ sb;
      rm_p1      <= round_mode;
      exp_p1     <= eff_big;
      big_p1     <= {e_big != '0, f_big, 3'b000};
      sml_p1     <= aligned;
    end
  end

  logic [XW:0]   sum;
  logic [XW-1:0] norm;
  logic [exp:0]  e_n;
  logic          sign_n;
  int            lz, lim, sh;

  always_comb begin
    sum = sub_p1 ? ({1'b0, big_p1} - {1'b0, sml_p1}) : ({1'b0, big_p1} + {1'b0, sml_p1});
    lz  = XW;
    for (int i = 0; i < XW; i++)
      if (sum[i]) lz = XW - 1 - i;
    lim = int'(exp_p1) - 1;
    sh  = (lz < lim) ? lz : lim;
    if (sum[XW]) begin
      norm = {sum[XW:2], sum[1] | sum[0]};
      e_n  = {1'b0, exp_p1} + X_ONE;
    end else begin
      norm = sum[XW-1:0] << sh;
      e_n  = {1'b0, exp_p1} - (exp+1)'(sh);
    end
    sign_n = (sum == '0 && sub_p1) ? (rm_p1 == RDN) : sign_p1;
  end

  // Stage 2 register: normalized magnitude
  logic           vld_p2, special_p2, inv_p2, sign_p2;
  logic [1:0]     rm_p2;
  logic [W-1:0]   spec_p2;
  logic [exp:0]   exp_p2;
  logic [XW-1:0]  norm_p2;

  always_ff @(posedge clk) begin
    if (adv) begin
      special_p2 <= special_p1;
      inv_p2     <= inv_p1;
      spec_p2    <= spec_p1;
      sign_p2    <= sign_n;
      rm_p2      <= rm_p1;
      exp_p2     <= e_n;
      norm_p2    <= norm;
    end
  end

  logic [frac:0]   kept;
  logic [frac+1:0] rnd;
  logic [exp:0]    e_r;
  logic [frac-1:0] f_r;
  logic            g, rs, inexact, tiny, carry, hidden, ovf;
  logic [W-1:0]    r_n;
  logic [4:0]      flags_n;

  always_comb begin
    kept    = norm_p2[XW-1:3];
    g       = norm_p2[2];
    rs      = |norm_p2[1:0];
    inexact = g | rs;
    tiny    = !norm_p2[XW-1];
    rnd     = {1'b0, kept} + {{(frac+1){1'b0}}, round_inc(rm_p2, sign_p2, kept[0], g, rs)};
    carry   = rnd[frac+1];
    hidden  = carry | rnd[frac];
    e_r     = carry ? exp_p2 + X_ONE : exp_p2;
    f_r     = carry ? rnd[frac:1] : rnd[frac-1:0];
    ovf     = e_r >= {1'b0, E_ONES};
    if (special_p2) begin
      r_n     = spec_p2;
      flags_n = {inv_p2, 4'b0000};
    end else if (ovf) begin
      r_n     = ovf_result(rm_p2, sign_p2);
      flags_n = 5'b00101;
    end else begin
      r_n     = {sign_p2, hidden ? e_r[exp-1:0] : {exp{1'b0}}, f_r};
      flags_n = {3'b000, tiny & inexact, inexact};
    end
  end

  // Stage 3 register: packed result, control and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      r         <= '0;
      flags     <= '0;
      flags_acc <= '0;
    end else begin
      if (adv) begin
        vld_p1    <= in_valid;
        vld_p2    <= vld_p1;
        out_valid <= vld_p2;
        if (vld_p2) begin
          r     <= r_n;
          flags <= flags_n;
        end
      end
      if (out_valid && out_ready)
        flags_acc <= flags_clr ? flags : (flags_acc | flags);
      else if (flags_clr)
        flags_acc <= '0;
    end
  end
endmodule

// File: tb/tb_fadd_pipe.sv
// Scoreboard bench for fadd_pipe (fp32): directed vectors push expected results,
// an independent monitor pops and compares on every delivered output.
module tb_fadd_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op, out_valid, out_ready, flags_clr;
  logic [31:0] a, b, r;
  logic [1:0]  round_mode;
  logic [4:0]  flags, flags_acc;

  fadd_pipe #(.exp(8), .frac(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .flags(flags),
    .flags_acc(flags_acc), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                       input logic [1:0] rm, input logic [31:0] er, input logic [4:0] ef);
    int  n;
    logic ok;
    @(negedge clk);
    a = ia; b = ib; op = iop; round_mode = rm; in_valid = 1'b1;
    n  = 0;
    ok = in_ready;
    while (!ok && n < 100) begin
      @(negedge clk);
      n++;
      ok = in_ready;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: in_ready=0 for %0d cycles, expected 1", n);
      in_valid = 1'b0;
      return;
    end
    q.push_back('{er, ef});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain_pending", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    #1;
  endtask

  // Monitor: pops on handshake, verifies stability while back-pressured
  logic        prev_stall = 1'b0;
  logic [31:0] prev_r;
  logic [4:0]  prev_f;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_r", r, prev_r);
        check("hold_flags", flags, prev_f);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: r=%h flags=%b with empty scoreboard", r, flags);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result_r", r, e.r);
          check("result_flags", flags, e.f);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = r;
      prev_f     = flags;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int lat, stale;
    logic saw_stall;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0;
    round_mode = RNE; out_ready = 1'b1; flags_clr = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_r", r, 0);
    check("reset_flags", flags, 0);
    check("reset_flags_acc", flags_acc, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: accepting edge is the first of three register edges
    issue(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h40400000, 5'b00000);
    lat = 0;
    while (lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    check("latency_edges_after_accept", lat, 2);
    drain();

    // Directed vectors, back-to-back
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RNE, 32'h7F800000, 5'b00101);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RTZ, 32'h7F7FFFFF, 5'b00101);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RUP, 32'h7F800000, 5'b00101);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RDN, 32'h7F7FFFFF, 5'b00101);
    issue(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RDN, 32'hFF800000, 5'b00101);
    issue(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RUP, 32'hFF7FFFFF, 5'b00101);
    issue(32'h7F800000, 32'h7F800000, 1'b1, RNE, 32'h7FC00000, 5'b10000);
    issue(32'h7FC00001, 32'h3F800000, 1'b0, RNE, 32'h7FC00000, 5'b10000);
    issue(32'h7F800000, 32'h3F800000, 1'b0, RNE, 32'h7F800000, 5'b00000);
    issue(32'h3F800000, 32'h7F800000, 1'b1, RNE, 32'hFF800000, 5'b00000);
    issue(32'h00800000, 32'h00400000, 1'b1, RNE, 32'h00400000, 5'b00000);
    issue(32'h3F800000, 32'h33800000, 1'b0, RNE, 32'h3F800000, 5'b00001);
    issue(32'h3F800000, 32'h33800000, 1'b0, RUP, 32'h3F800001, 5'b00001);
    issue(32'h00800001, 32'h00800000, 1'b1, RNE, 32'h00000001, 5'b00000);
    issue(32'h3F800000, 32'h3F800000, 1'b1, RNE, 32'h00000000, 5'b00000);
    issue(32'h3F800000, 32'h3F800000, 1'b1, RDN, 32'h80000000, 5'b00000);
    issue(32'h80000000, 32'h80000000, 1'b0, RNE, 32'h80000000, 5'b00000);
    issue(32'h3F800000, 32'hBFC00000, 1'b0, RNE, 32'hBF000000, 5'b00000);
    issue(32'hBF800000, 32'hB3800000, 1'b0, RDN, 32'hBF800001, 5'b00001);
    issue(32'h3F800001, 32'h33800000, 1'b0, RNE, 32'h3F800002, 5'b00001);
    issue(32'h00000001, 32'h00000001, 1'b0, RNE, 32'h00000002, 5'b00000);
    issue(32'h007FFFFF, 32'h00000001, 1'b0, RNE, 32'h00800000, 5'b00000);
    issue(32'h3F800000, 32'h33800000, 1'b1, RNE, 32'h3F7FFFFF, 5'b00000);
    issue(32'h3F800000, 32'h33000000, 1'b1, RNE, 32'h3F800000, 5'b00001);
    drain();

    // Back-pressure: five ops while the consumer stalls for six cycles
    @(posedge clk);
    #2 out_ready = 1'b0;
    saw_stall = 1'b0;
    fork
      begin
        issue(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h40400000, 5'b00000);
        issue(32'h3F800000, 32'h3F800000, 1'b1, RNE, 32'h00000000, 5'b00000);
        issue(32'h3F800000, 32'hBFC00000, 1'b0, RNE, 32'hBF000000, 5'b00000);
        issue(32'h00800001, 32'h00800000, 1'b1, RNE, 32'h00000001, 5'b00000);
        issue(32'h7FC00001, 32'h3F800000, 1'b0, RNE, 32'h7FC00000, 5'b10000);
      end
      begin
        repeat (6) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1'b1;
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    check("stall_in_ready_dropped", saw_stall, 1);
    drain();
    check("in_ready_released", in_ready, 1);

    // Sticky flags
    pulse_clr();
    check("acc_clear_idle", flags_acc, 0);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RNE, 32'h7F800000, 5'b00101);
    issue(32'h3F800000, 32'h33800000, 1'b0, RNE, 32'h3F800000, 5'b00001);
    drain();
    check("acc_ovf_inexact", flags_acc, 5'b00101);
    pulse_clr();
    check("acc_clear_no_handshake", flags_acc, 0);
    issue(32'h3F800000, 32'h33800000, 1'b0, RNE, 32'h3F800000, 5'b00001);
    drain();
    check("acc_inexact", flags_acc, 5'b00001);
    issue(32'h7FC00001, 32'h3F800000, 1'b0, RNE, 32'h7FC00000, 5'b10000);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("nan_out_valid", out_valid, 1);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    #1;
    check("acc_clear_with_handshake", flags_acc, 5'b10000);
    drain();

    // Reset with two operations in flight
    issue(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h40400000, 5'b00000);
    issue(32'h3F800000, 32'h3F800000, 1'b1, RNE, 32'h00000000, 5'b00000);
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_r", r, 0);
    check("mid_reset_flags_acc", flags_acc, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("no_stale_after_reset", stale, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
